// File: rtl/instr_fetch.sv
// IF stage: holds the PC, fetches over a req/ack instruction memory and registers {PC, instr}
// into the IF/ID bundle, with downstream stall (skid-buffered) and redirect flush.
// Optional performance counters are enabled with the INSTR_FETCH_PERF_EN macro.
module instr_fetch #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] PC_STEP   = 32'd4,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [63:0] ID,
`ifdef INSTR_FETCH_PERF_EN
    output logic        id_valid,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_bubbles
`else
    output logic        id_valid
`endif
);

    typedef enum logic [1:0] {
        StStart,
        StFetch,
        StHold
    } state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [63:0] id_q;
    logic        id_valid_q;
    logic        req_q;
    logic [63:0] skid_q;

    assign imem_req  = req_q;
    assign imem_addr = pc_q;
    assign ID        = id_q;
    assign id_valid  = id_valid_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= StStart;
            pc_q       <= RESET_PC;
            id_q       <= {RESET_PC, NOP_INSTR};
            id_valid_q <= 1'b0;
            req_q      <= 1'b0;
            skid_q     <= '0;
        end else begin
            unique case (state_q)
                StStart: begin
                    state_q <= StFetch;
                    req_q   <= 1'b1;
                end
                StFetch: begin
                    if (redirect) begin
                        // Any same-cycle ack belongs to the wrong path and is dropped.
                        pc_q       <= redirect_pc;
                        id_q       <= {redirect_pc, NOP_INSTR};
                        id_valid_q <= 1'b0;
                    end else if (imem_ack && !stall) begin
                        id_q       <= {pc_q, imem_rdata};
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_q + PC_STEP;
                    end else if (imem_ack && stall) begin
                        skid_q  <= {pc_q, imem_rdata};
                        state_q <= StHold;
                        req_q   <= 1'b0;
                    end else if (!stall) begin
                        id_q       <= {pc_q, NOP_INSTR};
                        id_valid_q <= 1'b0;
                    end
                end
                StHold: begin
                    if (redirect) begin
                        pc_q       <= redirect_pc;
                        id_q       <= {redirect_pc, NOP_INSTR};
                        id_valid_q <= 1'b0;
                        state_q    <= StFetch;
                        req_q      <= 1'b1;
                    end else if (!stall) begin
                        // pc only advances once the skid entry is actually consumed.
                        id_q       <= skid_q;
                        id_valid_q <= 1'b1;
                        pc_q       <= pc_q + PC_STEP;
                        state_q    <= StFetch;
                        req_q      <= 1'b1;
                    end
                end
                default: begin
                    state_q <= StStart;
                    req_q   <= 1'b0;
                end
            endcase
        end
    end

`ifdef INSTR_FETCH_PERF_EN
    logic        fetch_evt;
    logic        bubble_evt;
    logic [31:0] perf_fetched_q;
    logic [31:0] perf_bubbles_q;

    assign fetch_evt  = (state_q == StFetch && !redirect && imem_ack && !stall) ||
                        (state_q == StHold && !redirect && !stall);
    assign bubble_evt = (state_q == StFetch && (redirect || (!imem_ack && !stall))) ||
                        (state_q == StHold && redirect);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched_q <= '0;
            perf_bubbles_q <= '0;
        end else begin
            if (fetch_evt) begin
                perf_fetched_q <= perf_fetched_q + 32'd1;
            end
            if (bubble_evt) begin
                perf_bubbles_q <= perf_bubbles_q + 32'd1;
            end
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_bubbles = perf_bubbles_q;
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Scoreboard bench for instr_fetch: expected IF/ID state is queued as each cycle is driven and
// compared one clock later against the registered outputs.
module tb_instr_fetch;

    localparam logic [31:0] K   = 32'hA5A5_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    typedef struct packed {
        logic [63:0] id;
        logic        v;
        logic        req;
        logic [31:0] addr;
    } exp_t;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [63:0] ID;
    logic        id_valid;
    logic        ack_en;
`ifdef INSTR_FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clock = ~clock;

    // Stateless memory: answers whenever enabled, data is a fixed function of the address.
    assign imem_ack   = ack_en;
    assign imem_rdata = imem_addr ^ K;

    instr_fetch dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .ID          (ID),
`ifdef INSTR_FETCH_PERF_EN
        .id_valid    (id_valid),
        .perf_fetched(perf_fetched),
        .perf_bubbles(perf_bubbles)
`else
        .id_valid    (id_valid)
`endif
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ent(input logic [31:0] pc, input logic [31:0] ins);
        return {pc, ins};
    endfunction

    // Drive one cycle of inputs and queue the outputs expected after the next rising edge.
    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc, input logic ack,
                         input logic [63:0] e_id, input logic e_v, input logic e_req,
                         input logic [31:0] e_addr);
        exp_t e;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
        ack_en      = ack;
        e.id = e_id; e.v = e_v; e.req = e_req; e.addr = e_addr;
        sb.push_back(e);
        @(posedge clock);
        #2;
    endtask

    always @(posedge clock) begin
        exp_t e;
        #1;
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check("ID", ID, e.id);
            check("id_valid", {63'd0, id_valid}, {63'd0, e.v});
            check("imem_req", {63'd0, imem_req}, {63'd0, e.req});
            check("imem_addr", {32'd0, imem_addr}, {32'd0, e.addr});
        end
    end

    initial begin
        reset_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; ack_en = 1'b1;
        #2;
        check("rst_ID", ID, ent(32'h0, NOP));
        check("rst_valid", {63'd0, id_valid}, 64'd0);
        check("rst_req", {63'd0, imem_req}, 64'd0);
        check("rst_addr", {32'd0, imem_addr}, 64'd0);
        #10 reset_n = 1'b1;  // release at t=12, next edge at 15

        // START: ack while req low is ignored
        drive(0, 0, 0, 1, ent(32'h0, NOP), 0, 1, 32'h0);
        // Zero-wait streaming
        drive(0, 0, 0, 1, ent(32'h0, K ^ 32'h0), 1, 1, 32'h4);
        drive(0, 0, 0, 1, ent(32'h4, K ^ 32'h4), 1, 1, 32'h8);
        drive(0, 0, 0, 1, ent(32'h8, K ^ 32'h8), 1, 1, 32'hC);
        drive(0, 0, 0, 1, ent(32'hC, K ^ 32'hC), 1, 1, 32'h10);
        // Stall 3 cycles while the 0x10 ack lands in the skid
        drive(1, 0, 0, 1, ent(32'hC, K ^ 32'hC), 1, 0, 32'h10);
        drive(1, 0, 0, 1, ent(32'hC, K ^ 32'hC), 1, 0, 32'h10);
        drive(1, 0, 0, 1, ent(32'hC, K ^ 32'hC), 1, 0, 32'h10);
        drive(0, 0, 0, 1, ent(32'h10, K ^ 32'h10), 1, 1, 32'h14);
        drive(0, 0, 0, 1, ent(32'h14, K ^ 32'h14), 1, 1, 32'h18);
        // Redirect with simultaneous ack, then redirect beating stall
        drive(0, 1, 32'h400, 1, ent(32'h400, NOP), 0, 1, 32'h400);
        drive(0, 0, 0, 1, ent(32'h400, K ^ 32'h400), 1, 1, 32'h404);
        drive(1, 1, 32'h800, 1, ent(32'h800, NOP), 0, 1, 32'h800);
        // Ack every third cycle
        drive(0, 0, 0, 0, ent(32'h800, NOP), 0, 1, 32'h800);
        drive(0, 0, 0, 0, ent(32'h800, NOP), 0, 1, 32'h800);
        drive(0, 0, 0, 1, ent(32'h800, K ^ 32'h800), 1, 1, 32'h804);
        drive(0, 0, 0, 0, ent(32'h804, NOP), 0, 1, 32'h804);
        drive(0, 0, 0, 0, ent(32'h804, NOP), 0, 1, 32'h804);
        drive(0, 0, 0, 1, ent(32'h804, K ^ 32'h804), 1, 1, 32'h808);
        // No ack under stall holds ID
        drive(1, 0, 0, 0, ent(32'h804, K ^ 32'h804), 1, 1, 32'h808);
        drive(0, 0, 0, 1, ent(32'h808, K ^ 32'h808), 1, 1, 32'h80C);
        // PC wrap
        drive(0, 1, 32'hFFFF_FFFC, 0, ent(32'hFFFF_FFFC, NOP), 0, 1, 32'hFFFF_FFFC);
        drive(0, 0, 0, 1, ent(32'hFFFF_FFFC, 32'h5A5A_FFFC), 1, 1, 32'h0);
        drive(0, 0, 0, 1, ent(32'h0, K), 1, 1, 32'h4);
        // Redirect out of HOLD discards the skid entry
        drive(1, 0, 0, 1, ent(32'h0, K), 1, 0, 32'h4);
        drive(1, 1, 32'h100, 1, ent(32'h100, NOP), 0, 1, 32'h100);
        drive(0, 0, 0, 1, ent(32'h100, K ^ 32'h100), 1, 1, 32'h104);
        // Enter HOLD, then reset asynchronously
        drive(1, 0, 0, 1, ent(32'h100, K ^ 32'h100), 1, 0, 32'h104);
`ifdef INSTR_FETCH_PERF_EN
        check("perf_fetched", {32'd0, perf_fetched}, 64'd13);
        check("perf_bubbles", {32'd0, perf_bubbles}, 64'd8);
`endif
        #1 reset_n = 1'b0;
        #1;
        check("arst_ID", ID, ent(32'h0, NOP));
        check("arst_valid", {63'd0, id_valid}, 64'd0);
        check("arst_req", {63'd0, imem_req}, 64'd0);
        check("arst_addr", {32'd0, imem_addr}, 64'd0);
`ifdef INSTR_FETCH_PERF_EN
        check("arst_perf_fetched", {32'd0, perf_fetched}, 64'd0);
        check("arst_perf_bubbles", {32'd0, perf_bubbles}, 64'd0);
`endif
        @(posedge clock);
        #3 reset_n = 1'b1;
        drive(0, 0, 0, 1, ent(32'h0, NOP), 0, 1, 32'h0);
        drive(0, 0, 0, 1, ent(32'h0, K), 1, 1, 32'h4);
        drive(0, 0, 0, 1, ent(32'h4, K ^ 32'h4), 1, 1, 32'h8);
        #5;
        check("sb_drained", {32'd0, 32'(sb.size())}, 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
